// File: rtl/ppm_pkg.sv
// Shared types and default sizing for the PPM frame sequencer.
package ppm_pkg;

   // Frame sequencer states.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      WAIT  = 2'd2,
      SYNC  = 2'd3
   } state_t;

   // Width of one pulse-position value.
   localparam int POS_W = 8;

   // Default sizing.
   localparam int DEF_NCH      = 4;
   localparam int DEF_SYNC_LEN = 32;
   localparam int DEF_TIMEOUT  = 512;

   // Larger of two sizing values, used to size the shared gap timer.
   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/ppm_gap_timer.sv
// Down-counter shared by the WAIT timeout and the SYNC gap. A load arms
// it with (length - 1); expire is high on the final cycle of the interval.
module ppm_gap_timer #(
   parameter int W = 10
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         enable,
   output logic         expire
);

   logic [W-1:0] count;

   // Load takes priority; otherwise count down while enabled and hold at zero.
   // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (enable && (count != '0)) begin
         count <= count - 1'b1;
      end
   end

   assign expire = enable && (count == '0);

endmodule

// File: rtl/ppm_frame_sequencer.sv
// PPM frame sequencer: double-buffered slot positions, one encoder slot at
// a time, a fixed sync gap after the last slot, and a per-slot timeout.
module ppm_frame_sequencer
   import ppm_pkg::*;
#(
   parameter  int NCH      = DEF_NCH,
   parameter  int SYNC_LEN = DEF_SYNC_LEN,
   parameter  int TIMEOUT  = DEF_TIMEOUT,
   localparam int AW       = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             cfg_we,
   input  logic [AW-1:0]    cfg_addr,
   input  logic [POS_W-1:0] cfg_data,
   input  logic             err_clr,
   input  logic             enc_done,
   output logic             enc_start,
   output logic [POS_W-1:0] enc_pos,
   output logic [AW-1:0]    ch_idx,
   output logic             frame_sync,
   output logic             busy,
   output logic             err_timeout
);

   localparam int CNT_W = $clog2(max_int(SYNC_LEN, TIMEOUT) + 1);
   localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] SYNC_LOAD = CNT_W'(SYNC_LEN - 1);

   state_t           state;
   logic [POS_W-1:0] shadow [NCH];
   logic [POS_W-1:0] active [NCH];

   logic             last_slot;
   logic             advance;
   logic             commit;
   logic             timer_load;
   logic             timer_en;
   logic             timer_expire;
   logic [CNT_W-1:0] timer_val;
   logic [AW-1:0]    next_idx;

   assign last_slot = (int'(ch_idx) == NCH - 1);
   assign next_idx  = ch_idx + 1'b1;
   // A slot ends on enc_done or on the timer expiring; only WAIT listens.
   assign advance   = (state == WAIT) && (enc_done || timer_expire);
   // A frame starts from IDLE, or back-to-back at the end of the sync gap.
   assign commit    = en && ((state == IDLE) || ((state == SYNC) && timer_expire));
   assign timer_en  = (state == WAIT) || (state == SYNC);

   // Arm the timer for a slot timeout when leaving START, or for the sync gap after the last slot.
   // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
   always_comb begin
      timer_load = 1'b0;
      timer_val  = WAIT_LOAD;
      if (state == START) begin
         timer_load = 1'b1;
      end else if (advance && last_slot) begin
         timer_load = 1'b1;
         timer_val  = SYNC_LOAD;
      end
   end

   ppm_gap_timer #(
      .W (CNT_W)
   ) u_gap_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (timer_load),
      .load_val (timer_val),
      .enable   (timer_en),
      .expire   (timer_expire)
   );

   // Shadow bank: configuration writes, out-of-range slots dropped.
   // NOTE: the banks are small register arrays, so they can and do take the async reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NCH; i++) shadow[i] <= '0;
      end else if (cfg_we && (int'(cfg_addr) < NCH)) begin
         shadow[cfg_addr] <= cfg_data;
      end
   end

   // Frame FSM with registered outputs; commit copies the pre-edge shadow bank into active.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         ch_idx     <= '0;
         enc_start  <= 1'b0;
         enc_pos    <= '0;
         frame_sync <= 1'b0;
         busy       <= 1'b0;
         for (int i = 0; i < NCH; i++) active[i] <= '0;
      end else begin
         enc_start  <= 1'b0;
         frame_sync <= 1'b0;
         if (commit) begin
            active     <= shadow;
            enc_pos    <= shadow[0];
            ch_idx     <= '0;
            enc_start  <= 1'b1;
            frame_sync <= 1'b1;
            busy       <= 1'b1;
            state      <= START;
         end else begin
            case (state)
               START: state <= WAIT;
               WAIT: begin
                  if (advance) begin
                     if (!last_slot) begin
                        ch_idx    <= next_idx;
                        enc_pos   <= active[next_idx];
                        enc_start <= 1'b1;
                        state     <= START;
                     end else begin
                        state <= SYNC;
                     end
                  end
               end
               SYNC: begin
                  if (timer_expire) begin
                     busy  <= 1'b0;
                     state <= IDLE;
                  end
               end
               default: state <= state;
            endcase
         end
      end
   end

   // Sticky timeout flag; a new timeout wins over a same-cycle clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_timeout <= 1'b0;
      end else if (advance && !enc_done) begin
         err_timeout <= 1'b1;
      end else if (err_clr) begin
         err_timeout <= 1'b0;
      end
   end

endmodule

// File: tb/tb_ppm_frame_sequencer.sv
// Directed bench for ppm_frame_sequencer with a delay-programmable encoder model.
module tb_ppm_frame_sequencer;
   import ppm_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       en = 1'b0;
   logic       cfg_we = 1'b0;
   logic [1:0] cfg_addr = '0;
   logic [7:0] cfg_data = '0;
   logic       err_clr = 1'b0;
   logic       enc_done = 1'b0;
   logic       enc_start;
   logic [7:0] enc_pos;
   logic [1:0] ch_idx;
   logic       frame_sync;
   logic       busy;
   logic       err_timeout;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int f0 = 0;

   // Encoder model controls.
   bit auto_mode = 1'b0;
   bit glitch_start = 1'b0;
   bit force_done = 1'b0;
   int delay = 5;
   int cnt = 0;

   typedef struct {
      int         cyc;
      logic [7:0] pos;
      logic [1:0] idx;
   } start_rec_t;

   start_rec_t starts[$];
   int         syncs[$];

   ppm_frame_sequencer dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .en          (en),
      .cfg_we      (cfg_we),
      .cfg_addr    (cfg_addr),
      .cfg_data    (cfg_data),
      .err_clr     (err_clr),
      .enc_done    (enc_done),
      .enc_start   (enc_start),
      .enc_pos     (enc_pos),
      .ch_idx      (ch_idx),
      .frame_sync  (frame_sync),
      .busy        (busy),
      .err_timeout (err_timeout)
   );

   always #5 clk = ~clk;

   // Cycle counter: value k between posedges k and k+1.
   always @(posedge clk) cyc <= cyc + 1;

   // Encoder model: enc_done `delay` cycles after each enc_start, plus optional stray pulses.
   always @(negedge clk) begin
      enc_done = force_done;
      if (!rst_n) begin
         cnt = 0;
      end else begin
         if (cnt > 0) begin
            cnt = cnt - 1;
            if (cnt == 0) enc_done = 1'b1;
         end
         if (enc_start === 1'b1 && auto_mode) begin
            cnt = delay;
            if (glitch_start) enc_done = 1'b1;
         end
      end
   end

   // Logger of slot starts and frame commits.
   always @(negedge clk) begin
      if (rst_n) begin
         if (enc_start === 1'b1) starts.push_back('{cyc: cyc, pos: enc_pos, idx: ch_idx});
         if (frame_sync === 1'b1) syncs.push_back(cyc);
      end
   end

   task automatic cfg_write(input logic [1:0] a, input logic [7:0] d);
      @(negedge clk);
      cfg_we = 1'b1;
      cfg_addr = a;
      cfg_data = d;
      @(negedge clk);
      cfg_we = 1'b0;
   endtask

   task automatic wait_until(input int target);
      while (cyc < target) @(negedge clk);
   endtask

   task automatic wait_sync(input int budget, output int at);
      at = -1;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (frame_sync === 1'b1) begin
            at = cyc;
            break;
         end
      end
   endtask

   task automatic wait_starts(input int n, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (starts.size() >= n) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_idle(input int budget, output int at);
      at = -1;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (busy === 1'b0) begin
            at = cyc;
            break;
         end
      end
   endtask

   task automatic test_reset();
      logic [14:0] outs;
      en = 1'b1;
      #1 rst_n = 1'b0;
      #1;
      outs = {enc_start, enc_pos, ch_idx, frame_sync, busy, err_timeout};
      checks++;
      if (outs !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got %h expected 0", outs);
      end
      repeat (3) @(negedge clk);
      outs = {enc_start, enc_pos, ch_idx, frame_sync, busy, err_timeout};
      checks++;
      if (outs !== '0) begin
         errors++;
         $display("FAIL reset_hold_en: got %h expected 0", outs);
      end
      en = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL idle_en0_busy: got %b expected 0", busy);
      end
   endtask

   task automatic test_baseline();
      int exp_pos[5] = '{10, 20, 30, 40, 10};
      int exp_off[5] = '{0, 6, 12, 18, 56};
      int exp_idx[5] = '{0, 1, 2, 3, 0};
      bit ok;
      cfg_write(2'd0, 8'd10);
      cfg_write(2'd1, 8'd20);
      cfg_write(2'd2, 8'd30);
      cfg_write(2'd3, 8'd40);
      starts.delete();
      syncs.delete();
      auto_mode = 1'b1;
      delay = 5;
      en = 1'b1;
      wait_sync(5, f0);
      checks++;
      if (f0 < 0) begin
         errors++;
         $display("FAIL first_frame_sync: got none expected pulse within 5 cycles");
      end
      checks++;
      if ({enc_start, busy, ch_idx, enc_pos} !== {1'b1, 1'b1, 2'd0, 8'd10}) begin
         errors++;
         $display("FAIL first_start: got start=%b busy=%b idx=%0d pos=%0d expected 1 1 0 10",
                  enc_start, busy, ch_idx, enc_pos);
      end
      wait_starts(5, 100, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL baseline_starts: got %0d starts expected 5", starts.size());
      end
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (i >= starts.size()) begin
            errors++;
            $display("FAIL baseline_slot%0d: got missing expected pos %0d", i, exp_pos[i]);
         end else if (starts[i].pos !== 8'(exp_pos[i]) || starts[i].idx !== 2'(exp_idx[i]) ||
                      (starts[i].cyc - f0) != exp_off[i]) begin
            errors++;
            $display("FAIL baseline_slot%0d: got pos=%0d idx=%0d off=%0d expected %0d %0d %0d",
                     i, starts[i].pos, starts[i].idx, starts[i].cyc - f0,
                     exp_pos[i], exp_idx[i], exp_off[i]);
         end
      end
      checks++;
      if (syncs.size() < 2 || syncs[1] - syncs[0] != 56) begin
         errors++;
         $display("FAIL frame_period: got %0d syncs expected 2 spaced by 56", syncs.size());
      end
   endtask

   task automatic test_midframe_write();
      int exp_pos[10] = '{10, 20, 30, 40, 99, 20, 30, 40, 99, 77};
      bit ok;
      cfg_write(2'd0, 8'd99);
      // Write slot 1 on the cycle of the frame-3 commit edge.
      wait_until(f0 + 111);
      cfg_we = 1'b1;
      cfg_addr = 2'd1;
      cfg_data = 8'd77;
      @(negedge clk);
      cfg_we = 1'b0;
      checks++;
      if (frame_sync !== 1'b1 || enc_pos !== 8'd99) begin
         errors++;
         $display("FAIL frame3_commit: got sync=%b pos=%0d expected 1 99", frame_sync, enc_pos);
      end
      wait_starts(14, 200, ok);
      for (int i = 0; i < 10; i++) begin
         checks++;
         if (4 + i >= starts.size()) begin
            errors++;
            $display("FAIL midwrite_slot%0d: got missing expected %0d", 4 + i, exp_pos[i]);
         end else if (starts[4+i].pos !== 8'(exp_pos[i])) begin
            errors++;
            $display("FAIL midwrite_slot%0d: got %0d expected %0d", 4 + i, starts[4+i].pos, exp_pos[i]);
         end
      end
   endtask

   task automatic test_en_drop();
      bit ok;
      int at;
      wait_starts(15, 100, ok);
      en = 1'b0;
      wait_idle(100, at);
      checks++;
      if (at != f0 + 224) begin
         errors++;
         $display("FAIL en_drop_idle_cycle: got %0d expected %0d", at - f0, 224);
      end
      checks++;
      if (starts.size() != 16 || starts[15].pos !== 8'd40 || starts[15].cyc != f0 + 186) begin
         errors++;
         $display("FAIL en_drop_tail: got %0d starts expected 16 ending pos 40 at +186", starts.size());
      end
      repeat (70) @(negedge clk);
      checks++;
      if (starts.size() != 16 || syncs.size() != 4 || busy !== 1'b0) begin
         errors++;
         $display("FAIL en_drop_quiet: got starts=%0d syncs=%0d busy=%b expected 16 4 0",
                  starts.size(), syncs.size(), busy);
      end
   endtask

   task automatic test_ignore_done();
      int exp_pos[5] = '{10, 20, 30, 40, 10};
      int exp_off[5] = '{0, 6, 12, 18, 56};
      int f1;
      int at;
      bit ok;
      cfg_write(2'd0, 8'd10);
      cfg_write(2'd1, 8'd20);
      starts.delete();
      glitch_start = 1'b1;
      en = 1'b1;
      wait_sync(5, f1);
      checks++;
      if (f1 < 0) begin
         errors++;
         $display("FAIL glitch_frame_sync: got none expected pulse");
      end
      wait_until(f1 + 30);
      force_done = 1'b1;
      wait_until(f1 + 34);
      force_done = 1'b0;
      wait_starts(5, 100, ok);
      en = 1'b0;
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (i >= starts.size()) begin
            errors++;
            $display("FAIL glitch_slot%0d: got missing expected %0d", i, exp_pos[i]);
         end else if (starts[i].pos !== 8'(exp_pos[i]) || (starts[i].cyc - f1) != exp_off[i]) begin
            errors++;
            $display("FAIL glitch_slot%0d: got pos=%0d off=%0d expected %0d %0d",
                     i, starts[i].pos, starts[i].cyc - f1, exp_pos[i], exp_off[i]);
         end
      end
      glitch_start = 1'b0;
      wait_idle(100, at);
      checks++;
      if (at < 0) begin
         errors++;
         $display("FAIL glitch_idle: got busy expected idle");
      end
   endtask

   task automatic test_timeout();
      int f;
      int at;
      auto_mode = 1'b0;
      en = 1'b1;
      wait_sync(5, f);
      en = 1'b0;
      wait_until(f + 512);
      checks++;
      if ({err_timeout, ch_idx} !== 3'b000) begin
         errors++;
         $display("FAIL timeout_early: got err=%b idx=%0d expected 0 0", err_timeout, ch_idx);
      end
      @(negedge clk);
      checks++;
      if ({err_timeout, ch_idx, enc_start} !== {1'b1, 2'd1, 1'b1}) begin
         errors++;
         $display("FAIL timeout_advance: got err=%b idx=%0d start=%b expected 1 1 1",
                  err_timeout, ch_idx, enc_start);
      end
      wait_until(f + 600);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      checks++;
      if (err_timeout !== 1'b0) begin
         errors++;
         $display("FAIL err_clr: got %b expected 0", err_timeout);
      end
      // Clear coincides with the slot-1 timeout edge.
      wait_until(f + 1025);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      checks++;
      if ({err_timeout, ch_idx} !== {1'b1, 2'd2}) begin
         errors++;
         $display("FAIL timeout_vs_clr: got err=%b idx=%0d expected 1 2", err_timeout, ch_idx);
      end
      wait_idle(1200, at);
      checks++;
      if (at != f + 2084 || err_timeout !== 1'b1) begin
         errors++;
         $display("FAIL timeout_frame_end: got off=%0d err=%b expected 2084 1", at - f, err_timeout);
      end
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      checks++;
      if (err_timeout !== 1'b0) begin
         errors++;
         $display("FAIL err_clr_final: got %b expected 0", err_timeout);
      end
   endtask

   task automatic test_reset_midframe();
      logic [14:0] outs;
      int f;
      int r;
      int at;
      auto_mode = 1'b1;
      en = 1'b1;
      wait_sync(5, f);
      wait_until(f + 2);
      rst_n = 1'b0;
      #1;
      outs = {enc_start, enc_pos, ch_idx, frame_sync, busy, err_timeout};
      checks++;
      if (outs !== '0) begin
         errors++;
         $display("FAIL midframe_reset: got %h expected 0", outs);
      end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      r = cyc;
      checks++;
      if ({busy, enc_start} !== 2'b00) begin
         errors++;
         $display("FAIL reset_release_idle: got busy=%b start=%b expected 0 0", busy, enc_start);
      end
      @(negedge clk);
      checks++;
      if ({frame_sync, enc_start, enc_pos} !== {1'b1, 1'b1, 8'd0} || cyc != r + 1) begin
         errors++;
         $display("FAIL post_reset_frame: got sync=%b start=%b pos=%0d dcyc=%0d expected 1 1 0 1",
                  frame_sync, enc_start, enc_pos, cyc - r);
      end
      en = 1'b0;
      wait_idle(200, at);
      checks++;
      if (at < 0) begin
         errors++;
         $display("FAIL post_reset_idle: got busy expected idle");
      end
   endtask

   initial begin
      test_reset();
      test_baseline();
      test_midframe_write();
      test_en_drop();
      test_ignore_done();
      test_timeout();
      test_reset_midframe();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/ppm_frame_sequencer.md
PPM_FRAME_SEQUENCER -- requirements
Module: ppm_frame_sequencer

Interface
REQ-001 Parameter NCH, default 4: number of channel slots per frame.
REQ-002 Parameter SYNC_LEN, default 32: idle sync-gap length in clk cycles after the last channel.
REQ-003 Parameter TIMEOUT, default 512: maximum WAIT cycles before forced advance.
REQ-004 clk  in  1  single clock; all logic on its rising edge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 en  in  1  frame-run enable, level-sensitive.
REQ-007 cfg_we  in  1  shadow-register write strobe.
REQ-008 cfg_addr  in  clog2(NCH)  channel slot to write.
REQ-009 cfg_data  in  8  pulse position for that slot.
REQ-010 err_clr  in  1  clears err_timeout.
REQ-011 enc_done  in  1  one-cycle pulse from the PPM encoder: current pulse finished.
REQ-012 enc_start  out  1  one-cycle pulse to the encoder: begin a slot.
REQ-013 enc_pos  out  8  position for the slot, held stable from enc_start until enc_done or timeout.
REQ-014 ch_idx  out  clog2(NCH)  channel currently being encoded.
REQ-015 frame_sync  out  1  one-cycle pulse at each frame commit.
REQ-016 busy  out  1  high in every state except IDLE.
REQ-017 err_timeout  out  1  sticky flag: a slot timed out.

Function
REQ-018 The block SHALL hold two 8-bit banks of NCH entries each: shadow (written by cfg) and active (read by the FSM).
REQ-019 A cfg_we write SHALL update shadow[cfg_addr] at the clock edge; cfg_addr >= NCH SHALL be ignored.
REQ-020 The FSM SHALL have the states IDLE, START, WAIT and SYNC.
REQ-021 IDLE with en=1 SHALL commit shadow to active, pulse frame_sync, set ch_idx=0 and go to START on the same edge.
REQ-022 A commit SHALL copy pre-edge shadow contents; a cfg write on the commit cycle SHALL land in shadow only and apply from the next frame.
REQ-023 START SHALL assert enc_start for exactly one cycle with enc_pos=active[ch_idx], clear the WAIT timer and go to WAIT.
REQ-024 enc_done SHALL be sampled only in WAIT; enc_done in any other state SHALL be ignored.
REQ-025 WAIT with enc_done=1 SHALL go to START with ch_idx+1 if ch_idx<NCH-1, otherwise go to SYNC.
REQ-026 If WAIT lasts TIMEOUT cycles without enc_done, the block SHALL set err_timeout and advance as though enc_done had arrived.
REQ-027 SYNC SHALL last exactly SYNC_LEN cycles. At the end, en=1 SHALL commit, pulse frame_sync and go to START with ch_idx=0; en=0 SHALL go to IDLE.
REQ-028 Deasserting en mid-frame SHALL NOT abort the frame: remaining slots and SYNC complete first.
REQ-029 err_timeout SHALL clear on err_clr=1. A timeout and err_clr on the same cycle SHALL leave the flag set.
REQ-030 Position values SHALL pass unchanged to enc_pos, including 0 and 255.
REQ-031 Frame period SHALL equal the sum over slots of (1 + cycles to enc_done), plus SYNC_LEN.

Reset
REQ-032 rst_n=0 SHALL immediately force IDLE, ch_idx=0, enc_start=0, enc_pos=0, frame_sync=0, busy=0 and err_timeout=0.
REQ-033 Reset SHALL clear both banks and the WAIT/SYNC counters to 0.
REQ-034 Reset asserted mid-frame SHALL drop enc_start within the same cycle, without waiting for a clock edge.
REQ-035 The first frame SHALL start no earlier than the first edge after rst_n deasserts with en=1.

Structure
REQ-036 A shared package ppm_pkg SHALL hold the FSM state enum, a POS_W=8 constant and the default NCH, SYNC_LEN and TIMEOUT values.
REQ-037 The WAIT/SYNC cycle counter SHALL be a single sub-module, ppm_gap_timer (load, enable, expire), reused by both states.

Verification
REQ-038 Write slots 10/20/30/40 and set en=1; the encoder model returns enc_done 5 cycles after each start -> enc_pos sequence 10,20,30,40, then frame_sync at cycle 24+32 after the first.
REQ-039 Write slot 0=99 in the middle of a frame -> the current frame still emits 10, and the next frame emits 99.
REQ-040 Encoder model never returns enc_done -> err_timeout rises after 512 WAIT cycles, ch_idx advances, and err_clr clears the flag.
REQ-041 Drop en during slot 2 -> slots 2 and 3 and SYNC complete, then IDLE with busy=0 and no further enc_start.
REQ-042 Assert rst_n=0 during WAIT -> all outputs are 0 before the next edge, and after release with en=1 enc_pos=0 (cleared banks).
REQ-043 Pulse enc_done during START and SYNC -> ignored, and the sequence is unchanged from the baseline in REQ-038.
